// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the EX stage.
// Results wait in a private buffer and reach HI/LO when the busy period ends.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] L_MULT = 4'(MULT_CYCLES);
    localparam logic [3:0] L_DIV  = 4'(DIV_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_buf_hi;
    logic [31:0] r_buf_lo;
    logic        r_pend;

    logic        w_go;
    logic        w_is_div;
    logic        w_div_zero;
    logic        w_done;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_abs_n;
    logic [31:0] w_abs_d;
    logic [31:0] w_dvsr_u;
    logic [31:0] w_dvsr_s;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_go       = (r_state == S_IDLE) && Start && !MDOp[2];
    assign w_is_div   = MDOp[1];
    assign w_div_zero = (D2 == 32'd0);
    assign w_done     = (r_state == S_RUN) && (r_cnt == 4'd1);

    assign w_prod_s = $signed({{32{D1[31]}}, D1})
                    * $signed({{32{D2[31]}}, D2});
    assign w_prod_u = {32'd0, D1} * {32'd0, D2};

    // Signed divide via magnitudes; this also covers 0x80000000 / -1.
    assign w_abs_n  = D1[31] ? (~D1 + 32'd1) : D1;
    assign w_abs_d  = D2[31] ? (~D2 + 32'd1) : D2;
    assign w_dvsr_u = w_div_zero ? 32'd1 : D2;
    assign w_dvsr_s = w_div_zero ? 32'd1 : w_abs_d;
    assign w_q_u    = D1 / w_dvsr_u;
    assign w_r_u    = D1 % w_dvsr_u;
    assign w_q_mag  = w_abs_n / w_dvsr_s;
    assign w_r_mag  = w_abs_n % w_dvsr_s;
    assign w_q_s    = (D1[31] ^ D2[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_r_s    = D1[31] ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        unique case (MDOp[1:0])
            2'd0: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
            end
            2'd1: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
            end
            2'd2: begin
                w_res_hi = w_r_s;
                w_res_lo = w_q_s;
            end
            default: begin
                w_res_hi = w_r_u;
                w_res_lo = w_q_u;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_go) w_next = S_RUN;
            S_RUN:  if (w_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        Busy = (r_state == S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= 4'd0;
            r_buf_hi <= 32'd0;
            r_buf_lo <= 32'd0;
            r_pend   <= 1'b0;
            HI       <= 32'd0;
            LO       <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (w_go) begin
                r_cnt    <= w_is_div ? L_DIV : L_MULT;
                r_buf_hi <= w_res_hi;
                r_buf_lo <= w_res_lo;
                r_pend   <= !(w_is_div && w_div_zero);
            end else if (Start && MDOp == 3'd4) begin
                HI <= D1;
            end else if (Start && MDOp == 3'd5) begin
                LO <= D1;
            end
        end else begin
            r_cnt <= r_cnt - 4'd1;
            // A divide by zero keeps the full latency but commits nothing.
            if (w_done && r_pend) begin
                HI <= r_buf_hi;
                LO <= r_buf_lo;
            end
            if (w_done)
                r_pend <= 1'b0;
        end
    end

endmodule
